// File: rtl/candy_sram_arb_pkg.sv
// Shared widths, timeout default and FSM encoding for the candy SRAM arbiter.
package candy_sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 16;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned READ_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/candy_sram_arb_rr2.sv
// Two-way round-robin picker: the requester not granted last wins a tie.
module candy_rr2 (
  input  logic       req_f,
  input  logic       req_d,
  input  logic       last_d,
  output logic [1:0] gnt_c
);

  // last_d = 1 means the data port won the previous arbitration
  assign gnt_c[0] = req_f & (~req_d | last_d);
  assign gnt_c[1] = req_d & (~req_f | ~last_d);

endmodule

// File: rtl/candy_sram_arb.sv
// Arbitrates a fetch (read-only) port and a data port onto one single-ported SRAM,
// one access at a time, with a read timeout.
module candy_sram_arb
  import candy_sram_arb_pkg::*;
#(
  parameter int unsigned AW      = SRAM_ADDR_WIDTH,
  parameter int unsigned DW      = SRAM_DATA_WIDTH,
  parameter int unsigned TIMEOUT = READ_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          sram_re,
  output logic [AW-1:0] sram_raddr,
  output logic          sram_we,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  input  logic          sram_rdata_ready,
  output logic          busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_c;

  logic          f_gnt_d, d_gnt_d, f_valid_d, d_valid_d, f_err_d, d_err_d;
  logic [DW-1:0] f_rdata_d, d_rdata_d, sram_wdata_d;
  logic          sram_re_d, sram_we_d, busy_d;
  logic [AW-1:0] sram_raddr_d, sram_waddr_d;
  logic          rsp_fire;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;

  candy_rr2 u_rr2 (
    .req_f  (f_req),
    .req_d  (d_req),
    .last_d (rr_last_q),
    .gnt_c  (gnt_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    f_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    f_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    f_err_d      = 1'b0;
    d_err_d      = 1'b0;
    f_rdata_d    = f_rdata;
    d_rdata_d    = d_rdata;
    sram_re_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_raddr_d = sram_raddr;
    sram_waddr_d = sram_waddr;
    sram_wdata_d = sram_wdata;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_c != 2'b00) begin
          sel_d     = gnt_c[1];
          rr_last_d = gnt_c[1];
          cnt_d     = '0;
          f_gnt_d   = gnt_c[0];
          d_gnt_d   = gnt_c[1];
          // the fetch path never writes, whatever d_we says
          if (gnt_c[1] && d_we) begin
            state_d      = ST_WRITE;
            sram_we_d    = 1'b1;
            sram_waddr_d = d_addr;
            sram_wdata_d = d_wdata;
          end else begin
            state_d      = ST_READ;
            sram_re_d    = 1'b1;
            sram_raddr_d = gnt_c[1] ? d_addr : f_addr;
          end
        end
      end
      ST_READ: begin
        if (sram_rdata_ready) begin
          state_d  = ST_RESP;
          rsp_fire = 1'b1;
          rsp_data = sram_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = ST_RESP;
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          sram_re_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d   = ST_RESP;
        d_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route a read completion to the port that won arbitration
    if (rsp_fire) begin
      if (sel_q) begin
        d_valid_d = 1'b1;
        d_err_d   = rsp_err;
        d_rdata_d = rsp_data;
      end else begin
        f_valid_d = 1'b1;
        f_err_d   = rsp_err;
        f_rdata_d = rsp_data;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      f_valid    <= 1'b0;
      d_valid    <= 1'b0;
      f_err      <= 1'b0;
      d_err      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_raddr <= '0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      f_gnt      <= f_gnt_d;
      d_gnt      <= d_gnt_d;
      f_valid    <= f_valid_d;
      d_valid    <= d_valid_d;
      f_err      <= f_err_d;
      d_err      <= d_err_d;
      f_rdata    <= f_rdata_d;
      d_rdata    <= d_rdata_d;
      sram_re    <= sram_re_d;
      sram_we    <= sram_we_d;
      sram_raddr <= sram_raddr_d;
      sram_waddr <= sram_waddr_d;
      sram_wdata <= sram_wdata_d;
      busy       <= busy_d;
    end
  end

endmodule
